// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   state_e        : arbiter FSM state encoding (2-bit)
//   Unit*          : ALU_FUNC[3:2] unit-select codes of the shared ALU
//   TimeoutDefault : default WAIT-cycle budget before an error response
package alu_req_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

  localparam logic [1:0] UnitArith = 2'b00;
  localparam logic [1:0] UnitLogic = 2'b01;
  localparam logic [1:0] UnitCmp   = 2'b10;
  localparam logic [1:0] UnitShift = 2'b11;

  localparam int unsigned TimeoutDefault = 8;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-input round-robin grant, purely combinational.
//   req         : request vector, bit i = requester i
//   last_served : requester served most recently
//   gnt         : one-hot grant (all zero when no request)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that was not served last wins.
    if (req == 2'b11) begin
      gnt = last_served ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters.
// Round-robin arbitration in IDLE, operand/function latch, one-cycle ALU_EN in ISSUE,
// bounded wait for ALU_VALID in WAIT, one-cycle response pulse in RESP.
//   CLK, RST                  : clock, asynchronous active-low reset
//   REQ0/A0/B0/FUNC0          : requester 0 request level, operands, function
//   REQ1/A1/B1/FUNC1          : requester 1, same meaning
//   GNT                       : one-hot grant pulse (high during ISSUE)
//   RESP_VALID                : one-hot response pulse (high during RESP)
//   RESP_DATA, RESP_ERR       : result and timeout flag, held until next capture
//   ALU_A, ALU_B, ALU_FUNC    : latched operands/function to the ALU
//   ALU_EN                    : ALU enable
//   ALU_OUT, ALU_VALID        : registered ALU result and its valid flag
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 16,
  parameter int unsigned OUT_DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT        = TimeoutDefault,
  parameter int unsigned TO_CNT_W       = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ0,
  input  logic [IN_DATA_WIDTH-1:0]  A0,
  input  logic [IN_DATA_WIDTH-1:0]  B0,
  input  logic [3:0]                FUNC0,
  input  logic                      REQ1,
  input  logic [IN_DATA_WIDTH-1:0]  A1,
  input  logic [IN_DATA_WIDTH-1:0]  B1,
  input  logic [3:0]                FUNC1,
  output logic [1:0]                GNT,
  output logic [1:0]                RESP_VALID,
  output logic [OUT_DATA_WIDTH-1:0] RESP_DATA,
  output logic                      RESP_ERR,
  output logic [IN_DATA_WIDTH-1:0]  ALU_A,
  output logic [IN_DATA_WIDTH-1:0]  ALU_B,
  output logic [3:0]                ALU_FUNC,
  output logic                      ALU_EN,
  input  logic [OUT_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      ALU_VALID
);

  localparam logic [TO_CNT_W-1:0] CntMax = TO_CNT_W'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_served_q, last_served_d;
  logic [TO_CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_DATA_WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [IN_DATA_WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [3:0]                alu_func_q, alu_func_d;
  logic [OUT_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;

  logic [1:0] win;

  rr_arb2 u_rr_arb2 (
    .req        ({REQ1, REQ0}),
    .last_served(last_served_q),
    .gnt        (win)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_func_d    = alu_func_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (win != 2'b00) begin
          owner_d    = win[1];
          alu_a_d    = win[1] ? A1 : A0;
          alu_b_d    = win[1] ? B1 : B0;
          alu_func_d = win[1] ? FUNC1 : FUNC0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (ALU_VALID) begin
          resp_data_d = ALU_OUT;
          resp_err_d  = 1'b0;
          state_d     = StResp;
        end else if (cnt_q == CntMax) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_served_d = owner_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= '0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_func_q    <= alu_func_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // Pulses are decoded from registered state only, so no input reaches an output.
  assign GNT        = (state_q == StIssue) ? {owner_q, ~owner_q} : 2'b00;
  assign RESP_VALID = (state_q == StResp)  ? {owner_q, ~owner_q} : 2'b00;
  assign ALU_EN     = (state_q == StIssue);
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;
  assign ALU_FUNC   = alu_func_q;
  assign RESP_DATA  = resp_data_q;
  assign RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;

  localparam int Bound = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [3:0]  FUNC0 = '0, FUNC1 = '0;
  logic [1:0]  GNT, RESP_VALID;
  logic [15:0] RESP_DATA, ALU_A, ALU_B;
  logic        RESP_ERR, ALU_EN;
  logic [3:0]  ALU_FUNC;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;

  int checks = 0;
  int errors = 0;

  // ALU model controls
  int   alu_delay = 0;
  logic alu_never = 1'b0;

  alu_req_arbiter #(
    .IN_DATA_WIDTH (16),
    .OUT_DATA_WIDTH(16),
    .TIMEOUT       (8),
    .TO_CNT_W      (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ0      (REQ0),
    .A0        (A0),
    .B0        (B0),
    .FUNC0     (FUNC0),
    .REQ1      (REQ1),
    .A1        (A1),
    .B1        (B1),
    .FUNC1     (FUNC1),
    .GNT       (GNT),
    .RESP_VALID(RESP_VALID),
    .RESP_DATA (RESP_DATA),
    .RESP_ERR  (RESP_ERR),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_FUNC  (ALU_FUNC),
    .ALU_EN    (ALU_EN),
    .ALU_OUT   (ALU_OUT),
    .ALU_VALID (ALU_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
    logic [15:0] r;
    case (f[3:2])
      UnitArith: r = f[0] ? a - b : a + b;
      UnitLogic: r = (f[1:0] == 2'b00) ? (a & b) : (f[1:0] == 2'b01) ? (a | b) : (a ^ b);
      UnitCmp:   r = {15'd0, a == b};
      default:   r = f[0] ? (a >> b[3:0]) : (a << b[3:0]);
    endcase
    return r;
  endfunction

  // Registered ALU: flag 1 + alu_delay cycles after the enable cycle.
  int          alu_cnt;
  logic [15:0] alu_res;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_cnt   <= 0;
      alu_res   <= '0;
      ALU_VALID <= 1'b0;
      ALU_OUT   <= '0;
    end else begin
      ALU_VALID <= 1'b0;
      if (ALU_EN && !alu_never) begin
        if (alu_delay == 0) begin
          ALU_VALID <= 1'b1;
          ALU_OUT   <= alu_calc(ALU_A, ALU_B, ALU_FUNC);
        end else begin
          alu_cnt <= alu_delay;
          alu_res <= alu_calc(ALU_A, ALU_B, ALU_FUNC);
        end
      end else if (alu_cnt != 0) begin
        alu_cnt <= alu_cnt - 1;
        if (alu_cnt == 1) begin
          ALU_VALID <= 1'b1;
          ALU_OUT   <= alu_res;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (GNT == 2'b00 && n < Bound);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (RESP_VALID == 2'b00 && n < Bound);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({GNT, RESP_VALID, ALU_EN, RESP_ERR} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {GNT, RESP_VALID, ALU_EN, RESP_ERR});
    end
    checks++;
    if ({RESP_DATA, ALU_A, ALU_B, ALU_FUNC} !== 52'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {RESP_DATA, ALU_A, ALU_B, ALU_FUNC});
    end
  endtask

  task automatic test_single();
    A0 = 16'h00F0; B0 = 16'h0FF0; FUNC0 = 4'b0100; REQ0 = 1'b1;
    tick();  // cycle 1
    checks++;
    if (GNT !== 2'b01 || ALU_EN !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt got gnt=%b en=%b want gnt=01 en=1", GNT, ALU_EN);
    end
    REQ0 = 1'b0;
    tick();  // cycle 2
    checks++;
    if (GNT !== 2'b00 || ALU_EN !== 1'b0 || RESP_VALID !== 2'b00) begin
      errors++;
      $display("FAIL single_wait got gnt=%b en=%b rv=%b want 00 0 00", GNT, ALU_EN, RESP_VALID);
    end
    tick();  // cycle 3
    checks++;
    if (RESP_VALID !== 2'b01 || RESP_DATA !== 16'h00F0 || RESP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got rv=%b d=%h e=%b want 01 00f0 0", RESP_VALID, RESP_DATA,
               RESP_ERR);
    end
    tick();  // cycle 4
    checks++;
    if (RESP_VALID !== 2'b00 || RESP_DATA !== 16'h00F0) begin
      errors++;
      $display("FAIL single_hold got rv=%b d=%h want 00 00f0", RESP_VALID, RESP_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [1:0]  exp_g;
    logic [15:0] exp_d;
    do_reset();
    A0 = 16'h1234; B0 = 16'h0F0F; FUNC0 = 4'b0000;  // add -> 2143
    A1 = 16'h00FF; B1 = 16'h0F0F; FUNC1 = 4'b0110;  // xor -> 0ff0
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 16'h2143 : 16'h0FF0;
      wait_gnt(n);
      checks++;
      if (GNT !== exp_g || n != ((i == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL b2b_gnt%0d got %b after %0d want %b after %0d", i, GNT, n, exp_g,
                 (i == 0) ? 1 : 2);
      end
      tick();
      tick();
      checks++;
      if (RESP_VALID !== exp_g || RESP_DATA !== exp_d) begin
        errors++;
        $display("FAIL b2b_resp%0d got %b %h want %b %h", i, RESP_VALID, RESP_DATA, exp_g, exp_d);
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_rr_priority();
    int          n;
    logic [1:0]  exp_g;
    logic [15:0] exp_d;
    do_reset();
    A1 = 16'h0003; B1 = 16'h0004; FUNC1 = 4'b0001;  // sub -> ffff
    A0 = 16'h00F0; B0 = 16'h000F; FUNC0 = 4'b0101;  // or  -> 00ff
    REQ1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i == 1) ? 2'b01 : 2'b10;
      exp_d = (i == 1) ? 16'h00FF : 16'hFFFF;
      wait_gnt(n);
      checks++;
      if (GNT !== exp_g) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b want %b", i, GNT, exp_g);
      end
      if (i == 0) REQ0 = 1'b1;
      if (i == 1) REQ0 = 1'b0;
      if (i == 2) REQ1 = 1'b0;
      wait_resp(n);
      checks++;
      if (RESP_VALID !== exp_g || RESP_DATA !== exp_d) begin
        errors++;
        $display("FAIL rr_resp%0d got %b %h want %b %h", i, RESP_VALID, RESP_DATA, exp_g, exp_d);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    alu_never = 1'b1;
    A0 = 16'h0005; B0 = 16'h0005; FUNC0 = 4'b1000; REQ0 = 1'b1;
    wait_gnt(n);
    REQ0 = 1'b0;
    wait_resp(n);
    checks++;
    if (n != 9 || RESP_VALID !== 2'b01) begin
      errors++;
      $display("FAIL to_latency got %0d rv=%b want 9 rv=01", n, RESP_VALID);
    end
    checks++;
    if (RESP_ERR !== 1'b1 || RESP_DATA !== 16'h0000) begin
      errors++;
      $display("FAIL to_resp got e=%b d=%h want 1 0000", RESP_ERR, RESP_DATA);
    end
    tick();
    alu_never = 1'b0;
    A1 = 16'h0F00; B1 = 16'h00F0; FUNC1 = 4'b0101;  // or -> 0ff0
    REQ1 = 1'b1;
    wait_gnt(n);
    REQ1 = 1'b0;
    wait_resp(n);
    checks++;
    if (n != 2 || RESP_VALID !== 2'b10 || RESP_DATA !== 16'h0FF0 || RESP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL to_recover got n=%0d rv=%b d=%h e=%b want 2 10 0ff0 0", n, RESP_VALID,
               RESP_DATA, RESP_ERR);
    end
    tick();
  endtask

  task automatic test_slow_alu();
    int   n;
    int   en_count;
    logic unstable;
    alu_delay = 3;
    A0 = 16'h0001; B0 = 16'h0004; FUNC0 = 4'b1100;  // shl -> 0010
    REQ0 = 1'b1;
    wait_gnt(n);
    REQ0 = 1'b0;
    A0 = 16'hDEAD; B0 = 16'hBEEF; FUNC0 = 4'b0010;
    en_count = ALU_EN ? 1 : 0;
    unstable = 1'b0;
    n = 0;
    do begin
      if (ALU_A !== 16'h0001 || ALU_B !== 16'h0004 || ALU_FUNC !== 4'b1100) unstable = 1'b1;
      tick();
      n++;
      if (ALU_EN === 1'b1) en_count++;
    end while (RESP_VALID == 2'b00 && n < Bound);
    if (ALU_A !== 16'h0001 || ALU_B !== 16'h0004 || ALU_FUNC !== 4'b1100) unstable = 1'b1;
    checks++;
    if (n != 5 || RESP_VALID !== 2'b01 || RESP_DATA !== 16'h0010) begin
      errors++;
      $display("FAIL slow_resp got n=%0d rv=%b d=%h want 5 01 0010", n, RESP_VALID, RESP_DATA);
    end
    checks++;
    if (unstable !== 1'b0) begin
      errors++;
      $display("FAIL slow_stable got unstable=%b want 0", unstable);
    end
    checks++;
    if (en_count != 1) begin
      errors++;
      $display("FAIL slow_en got %0d enables want 1", en_count);
    end
    tick();
    alu_delay = 0;
  endtask

  task automatic test_reset_in_wait();
    int   n;
    logic seen;
    alu_delay = 3;
    A0 = 16'h0F0F; B0 = 16'h00FF; FUNC0 = 4'b0100;  // and -> 000f
    REQ0 = 1'b1;
    wait_gnt(n);
    REQ0 = 1'b0;
    tick();  // WAIT
    RST = 1'b0;
    #1;
    checks++;
    if ({GNT, RESP_VALID, ALU_EN, RESP_ERR} !== 6'b0 ||
        {RESP_DATA, ALU_A, ALU_B, ALU_FUNC} !== 52'h0) begin
      errors++;
      $display("FAIL rst_async got ctrl=%b data=%h want 0", {GNT, RESP_VALID, ALU_EN, RESP_ERR},
               {RESP_DATA, ALU_A, ALU_B, ALU_FUNC});
    end
    alu_delay = 0;
    seen = 1'b0;
    repeat (2) begin
      tick();
      if (RESP_VALID !== 2'b00) seen = 1'b1;
    end
    RST = 1'b1;
    repeat (6) begin
      tick();
      if (RESP_VALID !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp got seen=%b want 0", seen);
    end
    A0 = 16'h0003; B0 = 16'h0005; FUNC0 = 4'b0000;  // add -> 0008
    A1 = 16'h0001; B1 = 16'h0001; FUNC1 = 4'b0000;
    REQ0 = 1'b1; REQ1 = 1'b1;
    wait_gnt(n);
    checks++;
    if (GNT !== 2'b01 || n != 1) begin
      errors++;
      $display("FAIL rst_tie got %b after %0d want 01 after 1", GNT, n);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_resp(n);
    checks++;
    if (RESP_VALID !== 2'b01 || RESP_DATA !== 16'h0008 || n != 2) begin
      errors++;
      $display("FAIL rst_serve got %b %h n=%0d want 01 0008 2", RESP_VALID, RESP_DATA, n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_priority();
    test_timeout();
    test_slow_alu();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
